// File: rtl/true_count_calc_if.sv
// Request/result bundle between the card counter and the true-count calculator.
// The counter side is the master, and the calculator side is the slave.
interface true_count_calc_if;
  logic               calc_req;
  logic [7:0]         deck;
  logic [15:0]        total;
  logic signed [15:0] offset;
  logic               busy;
  logic signed [7:0]  tc;
  logic               tc_valid;
  logic [2:0]         bet;
  logic               div_zero;

  modport master (
    output calc_req, deck, total, offset,
    input  busy, tc, tc_valid, bet, div_zero
  );

  modport slave (
    input  calc_req, deck, total, offset,
    output busy, tc, tc_valid, bet, div_zero
  );
endinterface

// File: rtl/true_count_calc.sv
// True count calculator: tc = trunc(offset*52 / (52*deck - total)), saturated to +-127,
// computed with a 19-cycle restoring divider, and followed by a bet recommendation.
module true_count_calc (
  input  logic               clk,
  input  logic               rst,
  true_count_calc_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_e;

  state_e             state_q, state_d;
  logic [7:0]         deck_q, deck_d;
  logic [15:0]        total_q, total_d;
  logic signed [15:0] offset_q, offset_d;
  logic [13:0]        divisor_q, divisor_d;
  logic [13:0]        rem_q, rem_d;
  logic [18:0]        quot_q, quot_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic signed [7:0]  tc_q, tc_d;
  logic [2:0]         bet_q, bet_d;
  logic               valid_q, valid_d;
  logic               dz_q, dz_d;

  logic [16:0]        deckCards;
  logic [15:0]        offMag;
  logic [18:0]        dividend;
  logic [14:0]        remTrial;
  logic [14:0]        remSub;
  logic               fits;
  logic [6:0]         satMag;
  logic signed [7:0]  tcMag;
  logic signed [7:0]  tcRes;

  assign deckCards = 17'(deck_q) * 17'd52;
  assign offMag    = offset_q[15] ? (~offset_q + 16'd1) : offset_q;
  assign dividend  = 19'(offMag) * 19'd52;
  // The trial remainder is one bit wider so that the compare never wraps.
  assign remTrial  = {rem_q, quot_q[18]};
  assign remSub    = remTrial - {1'b0, divisor_q};
  assign fits      = remTrial >= {1'b0, divisor_q};
  assign satMag    = (|quot_q[18:7]) ? 7'd127 : quot_q[6:0];
  assign tcMag     = $signed({1'b0, satMag});
  assign tcRes     = zero_q ? 8'sd0 : (offset_q[15] ? -tcMag : tcMag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    deck_d    = deck_q;
    total_d   = total_q;
    offset_d  = offset_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    tc_d      = tc_q;
    bet_d     = bet_q;
    dz_d      = dz_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.calc_req) begin
          deck_d   = bus.deck;
          total_d  = bus.total;
          offset_d = bus.offset;
          zero_d   = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        divisor_d = 14'(deckCards - 17'(total_q));
        rem_d     = '0;
        quot_d    = dividend;
        cnt_d     = '0;
        zero_d    = deckCards <= 17'(total_q);
        state_d   = (deckCards <= 17'(total_q)) ? FIN : DIV;
      end
      DIV: begin
        // The quotient bits shift in at the LSB while the dividend shifts out of the MSB.
        rem_d  = fits ? remSub[13:0] : remTrial[13:0];
        quot_d = {quot_q[17:0], fits};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd18) state_d = FIN;
      end
      FIN: begin
        tc_d    = tcRes;
        dz_d    = zero_q;
        valid_d = 1'b1;
        if (tcRes <= 8'sd1)      bet_d = 3'd1;
        else if (tcRes >= 8'sd7) bet_d = 3'd7;
        else                     bet_d = tcRes[2:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deck_q    <= '0;
      total_q   <= '0;
      offset_q  <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      tc_q      <= '0;
      bet_q     <= 3'd1;
      valid_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      deck_q    <= deck_d;
      total_q   <= total_d;
      offset_q  <= offset_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      tc_q      <= tc_d;
      bet_q     <= bet_d;
      valid_q   <= valid_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy     = state_q != IDLE;
  assign bus.tc       = tc_q;
  assign bus.tc_valid = valid_q;
  assign bus.bet      = bet_q;
  assign bus.div_zero = dz_q;

endmodule

// File: doc/true_count_calc.md
TRUE_COUNT_CALC -- requirements
Module: true_count_calc

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock shared with the counter.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 calc_req  input  1  request pulse; starts one conversion when the block is idle.
REQ-005 deck  input  8  decks in shoe, unsigned, driven by the counter.
REQ-006 total  input  16  cards seen so far, unsigned, driven by the counter.
REQ-007 offset  input  16  signed running count, driven by the counter.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 tc  output  8  signed true count, registered.
REQ-010 tc_valid  output  1  one-cycle pulse; tc, bet and div_zero are updated in this cycle.
REQ-011 bet  output  3  recommended bet units, unsigned, registered.
REQ-012 div_zero  output  1  set when the last result had no cards remaining.

Function
REQ-013 The block SHALL compute tc = trunc_toward_zero(offset*52 / remaining), where remaining = 52*deck - total.
REQ-014 The block SHALL be an FSM with states IDLE, LOAD, DIV and FIN; busy SHALL be high in every state except IDLE.
REQ-015 In IDLE, when calc_req=1 at an edge (the accept edge), the FSM SHALL capture deck, total and offset and go to LOAD; later input changes SHALL NOT affect the result.
REQ-016 calc_req SHALL be ignored in every non-IDLE state; requests are not queued.
REQ-017 In LOAD, the block SHALL compute remaining in 14 bits unsigned and the dividend |offset|*52 in 19 bits unsigned.
REQ-018 In LOAD, if 52*deck <= total (this includes deck=0), the FSM SHALL go to FIN with the zero flag set; otherwise it SHALL go to DIV.
REQ-019 DIV SHALL be a restoring divider producing one quotient bit per cycle, MSB first, for exactly 19 cycles, then go to FIN.
REQ-020 In FIN, the block SHALL negate the magnitude if the captured offset < 0, saturate it to the range -127..+127, update tc, bet and div_zero, pulse tc_valid, and return to IDLE.
REQ-021 Latency (normal case): tc_valid SHALL be high in the cycle after the 21st rising edge following the accept edge.
REQ-022 Latency (zero case): tc_valid SHALL be high after the 2nd edge, with tc=0 and div_zero=1.
REQ-023 A normal result SHALL clear div_zero.
REQ-024 bet SHALL be 1 if tc <= 1, equal to tc if 2 <= tc <= 6, and 7 if tc >= 7.
REQ-025 tc, bet and div_zero SHALL hold their values between tc_valid pulses.
REQ-026 calc_req may be asserted in the same cycle as the tc_valid pulse; it SHALL then be accepted on the next edge, because the FSM is IDLE then.

Reset
REQ-027 When rst=0, regardless of clock: state=IDLE, busy=0, tc=0, tc_valid=0, bet=1, div_zero=0, all datapath registers cleared.
REQ-028 A reset during an operation SHALL abort it; no tc_valid pulse SHALL ever be produced for the aborted request.
REQ-029 Reset release SHALL be followed by normal IDLE behaviour at the first clock edge.

Verification
REQ-030 deck=1, total=0, offset=0, pulse calc_req -> busy for 21 cycles, then tc=0, bet=1, div_zero=0, one tc_valid pulse.
REQ-031 deck=2, total=52, offset=10 -> tc=10, bet=7.
REQ-032 deck=1, total=26, offset=-5 -> tc=-10, bet=1.
REQ-033 deck=6, total=100, offset=+7 -> tc=1 (364/212, truncated), bet=1; repeat with offset=-7 -> tc=-1, bet=1.
REQ-034 deck=1, total=51, offset=24 -> tc=127 (saturated), bet=7; then total=52 -> tc=0, div_zero=1, tc_valid 2 edges after accept.
REQ-035 Accept a request, pulse calc_req again at cycle 5 with different inputs -> only the first result is produced. Then assert rst=0 at cycle 10 of a new request -> busy=0 immediately and no tc_valid pulse.
